// File: rtl/watch_bcd_sched.sv
// Round-robin scheduler feeding one shared 8-bit binary-to-BCD (double-dabble) converter.
// Optional WATCH_BCD_OVF_EN adds an ovf output flagging a non-zero hundreds digit.
module watch_bcd_sched #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   req,
  input  logic [W-1:0] bin0,
  input  logic [W-1:0] bin1,
  input  logic [W-1:0] bin2,
  output logic [2:0]   gnt,
  output logic         busy,
  output logic         done,
  output logic [1:0]   done_id,
  output logic [3:0]   hun,
  output logic [3:0]   ten,
  output logic [3:0]   one
`ifdef WATCH_BCD_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   state;
  logic [1:0]   win;
  logic [1:0]   lg;
  logic [1:0]   pick;
  logic [W-1:0] op;
  logic [W-1:0] pick_bin;
  logic [11:0]  scr;
  logic [11:0]  scr_adj;
  logic [11:0]  scr_nxt;
  logic [2:0]   cnt;
  logic         sample;

  function automatic logic [3:0] adj(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Search order starts just after the last granted requester.
  always_comb begin
    pick = 2'd0;
    case (lg)
      2'd0:    if (req[1]) pick = 2'd1; else if (req[2]) pick = 2'd2; else pick = 2'd0;
      2'd1:    if (req[2]) pick = 2'd2; else if (req[0]) pick = 2'd0; else pick = 2'd1;
      default: if (req[0]) pick = 2'd0; else if (req[1]) pick = 2'd1; else pick = 2'd2;
    endcase
  end

  always_comb begin
    pick_bin = bin0;
    case (pick)
      2'd1:    pick_bin = bin1;
      2'd2:    pick_bin = bin2;
      default: pick_bin = bin0;
    endcase
  end

  // DONE also samples requests so back-to-back conversions run every 10 cycles.
  assign sample  = ((state == IDLE) || (state == DONE)) && (req != 3'b000);
  assign scr_adj = {adj(scr[11:8]), adj(scr[7:4]), adj(scr[3:0])};
  assign scr_nxt = {scr_adj[10:0], op[cnt]};

  assign busy = (state != IDLE);
  assign done = (state == DONE);
  assign gnt  = (state == LOAD) ? (3'b001 << win) : 3'b000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      win     <= 2'd0;
      lg      <= 2'd2;
      op      <= '0;
      scr     <= '0;
      cnt     <= 3'd0;
      done_id <= 2'd0;
      hun     <= 4'd0;
      ten     <= 4'd0;
      one     <= 4'd0;
`ifdef WATCH_BCD_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      case (state)
        LOAD: begin
          lg    <= win;
          scr   <= '0;
          cnt   <= 3'd7;
          state <= SHIFT;
        end
        SHIFT: begin
          scr <= scr_nxt;
          cnt <= cnt - 3'd1;
          // Result registers load on the last shift so they are valid alongside done.
          if (cnt == 3'd0) begin
            state   <= DONE;
            hun     <= scr_nxt[11:8];
            ten     <= scr_nxt[7:4];
            one     <= scr_nxt[3:0];
            done_id <= win;
`ifdef WATCH_BCD_OVF_EN
            ovf     <= (scr_nxt[11:8] != 4'd0);
`endif
          end
        end
        default: begin
          if (sample) begin
            state <= LOAD;
            win   <= pick;
            op    <= pick_bin;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_watch_bcd_sched.sv
// Self-checking bench for watch_bcd_sched: transaction-level model plus directed and random stimulus.
// Define WATCH_BCD_OVF_EN to also exercise the ovf output.
module tb_watch_bcd_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic [7:0] bin0 = 8'd0, bin1 = 8'd0, bin2 = 8'd0;
  logic [2:0] gnt;
  logic       busy, done;
  logic [1:0] done_id;
  logic [3:0] hun, ten, one;
`ifdef WATCH_BCD_OVF_EN
  logic       ovf;
`endif

  watch_bcd_sched #(.W(8)) dut (
    .clk(clk), .rst(rst), .req(req), .bin0(bin0), .bin1(bin1), .bin2(bin2),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .hun(hun), .ten(ten), .one(one)
`ifdef WATCH_BCD_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model: a conversion is a timeline counted in cycles since the sampling edge
  // (1 = grant, 10 = done); results are decimal arithmetic on the captured value.
  bit m_act;
  int m_age, m_win, m_val, m_lg, m_hun, m_ten, m_one, m_id;

  always @(posedge clk or posedge rst) begin : mdl
    int w;
    if (rst) begin
      m_act <= 1'b0; m_age <= 0; m_win <= 0; m_val <= 0; m_lg <= 2;
      m_hun <= 0; m_ten <= 0; m_one <= 0; m_id <= 0;
    end else begin
      w = -1;
      if ((!m_act || m_age == 10) && req != 3'b000) begin
        for (int i = 1; i <= 3; i++)
          if (w < 0 && req[(m_lg + i) % 3]) w = (m_lg + i) % 3;
        m_win <= w;
        m_val <= (w == 0) ? int'(bin0) : (w == 1) ? int'(bin1) : int'(bin2);
        m_lg  <= w;
        m_act <= 1'b1;
        m_age <= 1;
      end else if (m_act) begin
        if (m_age == 10) m_act <= 1'b0;
        else begin
          m_age <= m_age + 1;
          if (m_age == 9) begin
            m_hun <= m_val / 100;
            m_ten <= (m_val / 10) % 10;
            m_one <= m_val % 10;
            m_id  <= m_win;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", int'(gnt), (m_act && m_age == 1) ? (1 << m_win) : 0);
      check("done", int'(done), (m_act && m_age == 10) ? 1 : 0);
      check("busy", int'(busy), m_act ? 1 : 0);
      check("done_id", int'(done_id), m_id);
      check("digits", int'({hun, ten, one}), (m_hun << 8) | (m_ten << 4) | m_one);
`ifdef WATCH_BCD_OVF_EN
      check("ovf", int'(ovf), (m_hun != 0) ? 1 : 0);
`endif
      if (gnt != 3'b000 && done) check("gnt_done_overlap", 1, 0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_outputs", int'({gnt, busy, done, done_id, hun, ten, one}), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one request, drop it once granted, then check the result against literals.
  task automatic run_one(input logic [2:0] r, input int v, input int eh, input int et,
                         input int eo, input int eid);
    bit seen;
    req = r;
    case (eid)
      0: bin0 = 8'(v);
      1: bin1 = 8'(v);
      default: bin2 = 8'(v);
    endcase
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (gnt != 3'b000) seen = 1'b1;
    end
    check("gnt_seen", int'(seen), 1);
    check("gnt_value", int'(gnt), int'(r));
    req = 3'b000;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("done_seen", int'(seen), 1);
    check("lit_digits", int'({hun, ten, one}), (eh << 8) | (et << 4) | eo);
    check("lit_id", int'(done_id), eid);
`ifdef WATCH_BCD_OVF_EN
    check("lit_ovf", int'(ovf), (eh != 0) ? 1 : 0);
`endif
    @(negedge clk);
  endtask

  initial begin
    int ids[3];
    int dg[3];
    int tc[3];
    int n;
    bit seen;
    #1 chk_en = 1'b1;
    do_reset();

    run_one(3'b001, 255, 2, 5, 5, 0);
    run_one(3'b010, 0, 0, 0, 0, 1);
    run_one(3'b010, 59, 0, 5, 9, 1);
    run_one(3'b001, 100, 1, 0, 0, 0);
    run_one(3'b001, 99, 0, 9, 9, 0);

    // Round-robin with all three requesting continuously after reset.
    do_reset();
    bin0 = 8'd7; bin1 = 8'd42; bin2 = 8'd23;
    req = 3'b111;
    n = 0;
    for (int i = 0; i < 40 && n < 3; i++) begin
      @(negedge clk);
      if (done) begin
        ids[n] = int'(done_id);
        dg[n] = int'({hun, ten, one});
        tc[n] = cyc;
        n++;
        if (n == 3) req = 3'b000;
      end
    end
    check("rr_count", n, 3);
    check("rr_id0", ids[0], 0);
    check("rr_id1", ids[1], 1);
    check("rr_id2", ids[2], 2);
    check("rr_dig0", dg[0], 12'h007);
    check("rr_dig1", dg[1], 12'h042);
    check("rr_dig2", dg[2], 12'h023);
    check("rr_space01", tc[1] - tc[0], 10);
    check("rr_space12", tc[2] - tc[1], 10);
    repeat (3) @(negedge clk);

    // Reset during the 4th shift cycle of converting 200.
    req = 3'b001; bin0 = 8'd200;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (gnt != 3'b000) seen = 1'b1;
    end
    check("abort_gnt_seen", int'(seen), 1);
    req = 3'b000;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("abort_outputs", int'({gnt, busy, done, done_id, hun, ten, one}), 0);
    @(negedge clk);
    rst = 1'b0;
    run_one(3'b100, 13, 0, 1, 3, 2);

    for (int v = 0; v < 256; v++)
      run_one(3'b001, v, v / 100, (v / 10) % 10, v % 10, 0);

    // Random traffic: arbitrary request levels and operands, checked by the model.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      req  = 3'($urandom_range(0, 7));
      bin0 = 8'($urandom);
      bin1 = 8'($urandom);
      bin2 = 8'($urandom);
    end
    req = 3'b000;
    repeat (12) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/watch_bcd_sched.md
WATCH_BCD_SCHED -- requirements
Module: watch_bcd_sched

Interface
REQ-001 Parameter: W, 8, binary operand width; only 8 is supported.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: req  input  3  per-requester conversion request (0=seconds, 1=minutes, 2=hours); level, held until granted.
REQ-005 Port: bin0, bin1, bin2  input  W each  binary operand of requester 0/1/2; stable while its req is high.
REQ-006 Port: gnt  output  3  one-hot, one-cycle grant pulse to the accepted requester.
REQ-007 Port: busy  output  1  high whenever the state is not IDLE.
REQ-008 Port: done  output  1  one-cycle pulse; results valid.
REQ-009 Port: done_id  output  2  index of the requester whose result is on hun/ten/one; held until next done.
REQ-010 Port: hun, ten, one  output  4 each  BCD digits of the last completed conversion; held until next done.
REQ-011 Port: ovf  output  1  present only when the macro in REQ-027 is defined.

Function
REQ-012 FSM states: IDLE, LOAD, SHIFT, DONE; one state per clock unless stated otherwise.
REQ-013 IDLE: if req != 0 at a clock edge, go to LOAD; capture the winner index and its operand into an internal W-bit shift register; else stay in IDLE.
REQ-014 LOAD: gnt[winner] = 1 for exactly this cycle; clear the 12-bit BCD scratch register; set the bit counter to 7; go to SHIFT.
REQ-015 SHIFT: each cycle, add 3 to every scratch digit that is >= 5, then shift the scratch left by one with operand bit [counter] (MSB first) entering bit 0; decrement the counter; after the cycle with counter = 0 (8 SHIFT cycles total), go to DONE.
REQ-016 DONE: done = 1; hun/ten/one and done_id load from the scratch and winner; go to IDLE.
REQ-017 Latency: req sampled at edge k -> gnt high in cycle k+1 -> done high in cycle k+10; next request can be sampled at the edge that leaves DONE; one conversion per 10 cycles sustained.
REQ-018 Arbitration: round-robin; the search starts at (last_granted+1) mod 3; last_granted updates only on grant.
REQ-019 Simultaneous requests: exactly one grant per conversion; with req = 3'b111 held continuously, after reset, the grants occur in order 0,1,2,0,...
REQ-020 Requests asserted or dropped while busy are ignored until IDLE; a requester that drops req before its grant is not served; no request is queued.
REQ-021 Operand changes after capture (REQ-013) do not affect the conversion in progress.
REQ-022 Operand range 0..255 converts exactly; hun is 0..2 and never exceeds 2.
REQ-023 gnt and done are never high in the same cycle; at most one gnt bit is high.

Reset
REQ-024 On rst high (asynchronous): state = IDLE; gnt, done, busy = 0; hun/ten/one = 0; done_id = 0; scratch, counter and operand register = 0; last_granted = 2, so requester 0 has first priority.
REQ-025 Reset mid-conversion (LOAD/SHIFT/DONE) aborts it; no done pulse is produced for the aborted conversion; the held outputs read 0.
REQ-026 After rst deasserts, the first sampling edge behaves as IDLE.

Configuration
REQ-027 Macro WATCH_BCD_OVF_EN: when defined, the ovf output exists and loads in DONE with (hun != 0), flagging that the value exceeds the 2-digit display; it resets to 0 and holds with the digits. When undefined, the ovf port and its logic are absent; all other behaviour is identical.

Verification
REQ-028 req = 3'b001, bin0 = 255 -> gnt = 3'b001 one cycle later; done 9 cycles after gnt, with hun/ten/one = 2/5/5 and done_id = 0.
REQ-029 req = 3'b010, bin1 = 0 -> hun/ten/one = 0/0/0, done_id = 1; bin1 = 59 -> 0/5/9.
REQ-030 req = 3'b111 held after reset, bin0/1/2 = 7/42/23 -> done_id sequence 0,1,2 with 0/0/7, 0/4/2, 0/2/3; done pulses spaced 10 cycles apart.
REQ-031 Assert rst during the 4th SHIFT cycle of converting 200 -> all outputs 0 immediately, no done pulse; after release, req = 3'b100, bin2 = 13 -> 0/1/3 and done_id = 2.
REQ-032 With WATCH_BCD_OVF_EN: bin0 = 100 -> ovf = 1 with 1/0/0; bin0 = 99 -> ovf = 0 with 0/9/9.
REQ-033 Sweep all 256 operands on requester 0 -> digits match the decimal value; gnt and done never overlap.
